// File: rtl/epochtv1_vram_arb.sv
// EPOCH TV-1 VRAM bank arbiter: video fetch has priority, the CPU is
// guaranteed a slot after CPU_MAX_WAIT lost ticks. Reads return 2 ticks after grant.
module epochtv1_vram_arb #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_A,
  output logic          VID_ACK,
  output logic [DW-1:0] VID_D,
  output logic          VID_DV,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_A,
  input  logic [DW-1:0] CPU_DI,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_DO,
  output logic          CPU_DV,
  output logic [AW-1:0] VA,
  output logic [DW-1:0] VD_O,
  input  logic [DW-1:0] VD_I,
  output logic          nVRD,
  output logic          nVWR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VRD,
    S_CRD,
    S_CWR
  } slot_e;

  localparam logic [7:0] MAXW = 8'(CPU_MAX_WAIT);

  slot_e         slot_q, slot_d;
  logic [7:0]    wait_q, wait_d;
  logic [AW-1:0] va_q, va_d;
  logic [DW-1:0] vdo_q, vdo_d;
  logic          nvrd_q, nvrd_d;
  logic          nvwr_q, nvwr_d;
  logic          vack_q, vack_d;
  logic          cack_q, cack_d;
  logic          t1_v_q, t1_v_d;
  logic          t1_c_q, t1_c_d;
  logic          t2_v_q, t2_c_q;
  logic          vdv_q, vdv_d;
  logic          cdv_q, cdv_d;
  logic [DW-1:0] vd_q, vd_d;
  logic [DW-1:0] cdo_q, cdo_d;
  logic          cpu_el;
  logic          cpu_force;
  logic          cpu_win;

  always_comb begin
    slot_d    = S_IDLE;
    wait_d    = wait_q;
    va_d      = va_q;
    vdo_d     = vdo_q;
    nvrd_d    = 1'b1;
    nvwr_d    = 1'b1;
    // The CPU holds its request until it sees ACK, so the tick
    // after a CPU grant still shows the stale request.
    cpu_el    = CPU_REQ & (slot_q != S_CRD) & (slot_q != S_CWR);
    cpu_force = cpu_el & (wait_q >= MAXW);
    if (cpu_force) begin
      slot_d = CPU_WE ? S_CWR : S_CRD;
    end else if (VID_REQ) begin
      slot_d = S_VRD;
    end else if (cpu_el) begin
      slot_d = CPU_WE ? S_CWR : S_CRD;
    end
    cpu_win = (slot_d == S_CRD) | (slot_d == S_CWR);
    if (!cpu_el || cpu_win) begin
      wait_d = '0;
    end else if (slot_d == S_VRD && wait_q < MAXW) begin
      wait_d = wait_q + 8'd1;
    end
    unique case (slot_d)
      S_VRD: begin
        va_d   = VID_A;
        nvrd_d = 1'b0;
      end
      S_CRD: begin
        va_d   = CPU_A;
        nvrd_d = 1'b0;
      end
      S_CWR: begin
        va_d   = CPU_A;
        vdo_d  = CPU_DI;
        nvwr_d = 1'b0;
      end
      default: ;
    endcase
    vack_d = (slot_d == S_VRD);
    cack_d = cpu_win;
    t1_v_d = (slot_d == S_VRD) | (slot_d == S_CRD);
    t1_c_d = (slot_d == S_CRD);
    vdv_d  = t2_v_q & ~t2_c_q;
    cdv_d  = t2_v_q & t2_c_q;
    vd_d   = vdv_d ? VD_I : vd_q;
    cdo_d  = cdv_d ? VD_I : cdo_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_q <= S_IDLE;
      wait_q <= '0;
      va_q   <= '0;
      vdo_q  <= '0;
      nvrd_q <= 1'b1;
      nvwr_q <= 1'b1;
      vack_q <= 1'b0;
      cack_q <= 1'b0;
      t1_v_q <= 1'b0;
      t1_c_q <= 1'b0;
      t2_v_q <= 1'b0;
      t2_c_q <= 1'b0;
      vdv_q  <= 1'b0;
      cdv_q  <= 1'b0;
      vd_q   <= '0;
      cdo_q  <= '0;
    end else if (CE) begin
      slot_q <= slot_d;
      wait_q <= wait_d;
      va_q   <= va_d;
      vdo_q  <= vdo_d;
      nvrd_q <= nvrd_d;
      nvwr_q <= nvwr_d;
      vack_q <= vack_d;
      cack_q <= cack_d;
      t1_v_q <= t1_v_d;
      t1_c_q <= t1_c_d;
      t2_v_q <= t1_v_q;
      t2_c_q <= t1_c_q;
      vdv_q  <= vdv_d;
      cdv_q  <= cdv_d;
      vd_q   <= vd_d;
      cdo_q  <= cdo_d;
    end
  end

  assign VA      = va_q;
  assign VD_O    = vdo_q;
  assign nVRD    = nvrd_q;
  assign nVWR    = nvwr_q;
  assign VID_ACK = vack_q;
  assign CPU_ACK = cack_q;
  assign VID_DV  = vdv_q;
  assign CPU_DV  = cdv_q;
  assign VID_D   = vd_q;
  assign CPU_DO  = cdo_q;

endmodule
